// File: rtl/vga_sync_gen.sv
// Porch-framed video timing generator: column/row counters with a
// registered sync, active and frame-start decode aligned to the counts.
module vga_sync_gen #(
  parameter int unsigned c_ACTIVE_COLS = 640,
  parameter int unsigned c_H_FRONT     = 16,
  parameter int unsigned c_H_SYNC      = 96,
  parameter int unsigned c_H_BACK      = 48,
  parameter int unsigned c_ACTIVE_ROWS = 480,
  parameter int unsigned c_V_FRONT     = 10,
  parameter int unsigned c_V_SYNC      = 2,
  parameter int unsigned c_V_BACK      = 33,
  parameter bit          c_SYNC_POL    = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Pix_En,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start
);

  localparam int unsigned TOTAL_COLS =
    c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC + c_H_BACK;
  localparam int unsigned TOTAL_ROWS =
    c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC + c_V_BACK;

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST =
    10'(c_ACTIVE_COLS + c_H_FRONT);
  localparam logic [9:0] HS_LAST  =
    10'(c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC - 1);
  localparam logic [9:0] VS_FIRST =
    10'(c_ACTIVE_ROWS + c_V_FRONT);
  localparam logic [9:0] VS_LAST  =
    10'(c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC - 1);

  logic [9:0] col;
  logic [9:0] row;
  logic       col_wrap;
  logic       row_wrap;
  logic       act_d;
  logic       hs_d;
  logic       vs_d;
  logic       origin;

  always_comb begin
    col_wrap = (col == COL_LAST);
    row_wrap = (row == ROW_LAST);
    origin   = (col == 10'd0) && (row == 10'd0);
    act_d    = (col < ACT_COLS) && (row < ACT_ROWS);
    hs_d     = ~c_SYNC_POL;
    vs_d     = ~c_SYNC_POL;
    if ((col >= HS_FIRST) && (col <= HS_LAST))
      hs_d = c_SYNC_POL;
    if ((row >= VS_FIRST) && (row <= VS_LAST))
      vs_d = c_SYNC_POL;
  end

  // Row only advances on the column wrap, so both wrap together at frame end.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col <= 10'd0;
      row <= 10'd0;
    end else if (i_Pix_En) begin
      if (col_wrap) begin
        col <= 10'd0;
        row <= row_wrap ? 10'd0 : row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_HSync       <= ~c_SYNC_POL;
      o_VSync       <= ~c_SYNC_POL;
      o_Active      <= 1'b0;
      o_Col_Count   <= 10'd0;
      o_Row_Count   <= 10'd0;
      o_Frame_Start <= 1'b0;
    end else begin
      // Pulse is registered every clock so it stays one clock wide.
      o_Frame_Start <= i_Pix_En && origin;
      if (i_Pix_En) begin
        o_HSync     <= hs_d;
        o_VSync     <= vs_d;
        o_Active    <= act_d;
        o_Col_Count <= col;
        o_Row_Count <= row;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default-timing instance and a
// small-timing active-high-sync instance checked against a pixel-index model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] col;
    logic [9:0] row;
    logic       fs;
  } out_t;

  localparam int D_AC = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_AR = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int S_AC = 8,   S_HF = 2,  S_HS = 3,  S_HB = 3;
  localparam int S_AR = 6,   S_VF = 2,  S_VS = 2,  S_VB = 2;
  localparam int NCYC = 12000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic d_rst, d_en, s_rst, s_en;
  logic d_hs, d_vs, d_act, d_fs, s_hs, s_vs, s_act, s_fs;
  logic [9:0] d_col, d_row, s_col, s_row;

  vga_sync_gen u_dflt (
    .i_Clk(clk), .i_Reset(d_rst), .i_Pix_En(d_en),
    .o_HSync(d_hs), .o_VSync(d_vs), .o_Active(d_act),
    .o_Col_Count(d_col), .o_Row_Count(d_row),
    .o_Frame_Start(d_fs)
  );

  vga_sync_gen #(
    .c_ACTIVE_COLS(S_AC), .c_H_FRONT(S_HF),
    .c_H_SYNC(S_HS), .c_H_BACK(S_HB),
    .c_ACTIVE_ROWS(S_AR), .c_V_FRONT(S_VF),
    .c_V_SYNC(S_VS), .c_V_BACK(S_VB),
    .c_SYNC_POL(1'b1)
  ) u_small (
    .i_Clk(clk), .i_Reset(s_rst), .i_Pix_En(s_en),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_Active(s_act),
    .o_Col_Count(s_col), .o_Row_Count(s_row),
    .o_Frame_Start(s_fs)
  );

  out_t qd[$];
  out_t qs[$];
  int checks = 0;
  int failures = 0;

  // Pixel index p counts raster positions from the frame origin.
  function automatic out_t present(
    int p, int ac, int hf, int hsw, int hb,
    int ar, int vf, int vsw, bit pol
  );
    out_t o;
    int tc, c, r;
    tc = ac + hf + hsw + hb;
    c = p % tc;
    r = p / tc;
    o.col = 10'(c);
    o.row = 10'(r);
    o.act = (c < ac) && (r < ar);
    o.hs = (c >= ac + hf && c < ac + hf + hsw) ? pol : !pol;
    o.vs = (r >= ar + vf && r < ar + vf + vsw) ? pol : !pol;
    o.fs = 1'b0;
    return o;
  endfunction

  function automatic out_t reset_out(bit pol);
    out_t o;
    o = '0;
    o.hs = !pol;
    o.vs = !pol;
    return o;
  endfunction

  task automatic compare(
    input string name, input int k, input out_t got, input out_t exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b act=%b col=%0d row=%0d fs=%b exp hs=%b vs=%b act=%b col=%0d row=%0d fs=%b",
        name, k, got.hs, got.vs, got.act, got.col, got.row, got.fs,
        exp.hs, exp.vs, exp.act, exp.col, exp.row, exp.fs);
    end
  endtask

  int mcyc = 0;
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (qd.size() > 0) begin
        e = qd.pop_front();
        compare("dflt", mcyc, {d_hs, d_vs, d_act, d_col, d_row, d_fs}, e);
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        compare("small", mcyc, {s_hs, s_vs, s_act, s_col, s_row, s_fs}, e);
      end
    end
  end

  initial begin
    int dp, sp, dframe, sframe;
    out_t dl, sl, e;
    dframe = (D_AC + D_HF + D_HS + D_HB) * (D_AR + D_VF + D_VS + D_VB);
    sframe = (S_AC + S_HF + S_HS + S_HB) * (S_AR + S_VF + S_VS + S_VB);
    dp = 0;
    sp = 0;
    dl = reset_out(1'b0);
    sl = reset_out(1'b1);
    d_rst = 1'b1; d_en = 1'b0; s_rst = 1'b1; s_en = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      d_rst = (k < 3) || (k == 5500) || (k > 5000 && $urandom_range(0, 1999) == 0);
      if (k < 1700) d_en = 1'b1;
      else if (k < 5000) d_en = k[0];
      else d_en = ($urandom_range(0, 3) != 0);
      s_rst = (k < 3) || (k == 3100) || (k == 3150) ||
              (k > 3000 && $urandom_range(0, 499) == 0);
      if (k < 3000) s_en = 1'b1;
      else s_en = $urandom_range(0, 1) == 1;

      if (d_rst) begin
        dl = reset_out(1'b0);
        dp = 0;
      end else begin
        if (d_en) begin
          dl = present(dp, D_AC, D_HF, D_HS, D_HB, D_AR, D_VF, D_VS, 1'b0);
          dp = (dp + 1) % dframe;
        end
        dl.fs = d_en && (dl.col == 10'd0) && (dl.row == 10'd0) && d_en;
        if (!d_en) dl.fs = 1'b0;
      end
      qd.push_back(dl);

      if (s_rst) begin
        sl = reset_out(1'b1);
        sp = 0;
      end else begin
        if (s_en) begin
          sl = present(sp, S_AC, S_HF, S_HS, S_HB, S_AR, S_VF, S_VS, 1'b1);
          sp = (sp + 1) % sframe;
          sl.fs = (sl.col == 10'd0) && (sl.row == 10'd0);
        end else begin
          sl.fs = 1'b0;
        end
      end
      qs.push_back(sl);
    end
    @(posedge clk);
    #2;
    checks++;
    if (qd.size() + qs.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", qd.size() + qs.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
